// File: rtl/fir_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_sched_pkg
// Brief    : Shared types, default widths and index helper for the serial FIR.
// Revision : 1.0 - initial release
// ============================================================================
package fir_sched_pkg;

  localparam int C_DATA_W   = 12;
  localparam int C_COEF_W   = 12;
  localparam int C_NUM_TAPS = 20;
  localparam int C_ACC_W    = 29;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // (idx - dec) mod n for idx, dec < n; n need not be a power of two.
  function automatic int unsigned mod_sub(input int unsigned idx,
                                          input int unsigned dec,
                                          input int unsigned n);
    if (idx >= dec) begin
      return idx - dec;
    end
    return idx + n - dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sample_ring.sv
`default_nettype none
// ============================================================================
// Module   : fir_sample_ring
// Brief    : NUM_TAPS x DATA_W sample delay line, one write port, async read.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sample_ring #(
  parameter int DATA_W   = 12,
  parameter int NUM_TAPS = 20,
  parameter int AW       = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [NUM_TAPS];

  // History is wiped on reset so a fresh run starts from an all-zero line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (32'(waddr) < NUM_TAPS)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < NUM_TAPS) ? mem_q[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/fir_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_scheduler
// Brief    : Time-multiplexed FIR: one multiplier/accumulator, one tap/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fir_serial_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int COEF_W   = C_COEF_W,
  parameter int NUM_TAPS = C_NUM_TAPS,
  parameter int ACC_W    = C_ACC_W,
  parameter int TAP_AW   = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [TAP_AW-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              cfg_err
);

  localparam int                PROD_W     = DATA_W + COEF_W;
  localparam logic [TAP_AW-1:0] C_LAST_TAP = TAP_AW'(NUM_TAPS - 1);

  state_t                    state_q,    state_d;
  logic [TAP_AW-1:0]         k_q,        k_d;
  logic [TAP_AW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic signed [ACC_W-1:0]   acc_q,      acc_d;
  logic [ACC_W-1:0]          out_data_q, out_data_d;
  logic                      cfg_err_q,  cfg_err_d;
  logic signed [COEF_W-1:0]  coef_q [NUM_TAPS];
  logic signed [COEF_W-1:0]  coef_d [NUM_TAPS];

  logic                      ring_we;
  logic [TAP_AW-1:0]         rd_idx;
  logic [DATA_W-1:0]         ring_rd;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      coef_addr_ok;
  logic                      coef_wr_ok;

  fir_sample_ring #(
    .DATA_W   (DATA_W),
    .NUM_TAPS (NUM_TAPS),
    .AW       (TAP_AW)
  ) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ring_we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_idx),
    .rdata (ring_rd)
  );

  // Tap k reads the sample k positions older than the newest one at wr_ptr.
  assign rd_idx   = TAP_AW'(mod_sub(32'(wr_ptr_q), 32'(k_q), NUM_TAPS));
  assign prod     = PROD_W'($signed(ring_rd)) * PROD_W'(coef_q[k_q]);
  assign prod_ext = ACC_W'(prod);
  assign acc_sum  = acc_q + prod_ext;

  assign coef_addr_ok = (32'(coef_addr) < NUM_TAPS);
  assign coef_wr_ok   = coef_we && coef_addr_ok && (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wr_ptr_d   = wr_ptr_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    cfg_err_d  = cfg_err_q;
    coef_d     = coef_q;
    ring_we    = 1'b0;

    // A write in the accept cycle lands before tap 0 is read on the next edge.
    if (coef_wr_ok) begin
      coef_d[coef_addr] = coef_wdata;
    end
    if (coef_we && !coef_wr_ok) begin
      cfg_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ring_we = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == C_LAST_TAP) begin
          out_data_d = acc_sum;
          k_d        = '0;
          wr_ptr_d   = (wr_ptr_q == C_LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      wr_ptr_q   <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wr_ptr_q   <= wr_ptr_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      cfg_err_q  <= cfg_err_d;
      coef_q     <= coef_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_serial_scheduler
// Brief    : Scoreboard bench for the serial FIR scheduler with a tap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_serial_scheduler;

  localparam int DATA_W = 12;
  localparam int COEF_W = 12;
  localparam int N      = 20;
  localparam int ACC_W  = 29;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              cfg_err;

  fir_serial_scheduler #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .NUM_TAPS (N),
    .ACC_W    (ACC_W),
    .TAP_AW   (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic signed [DATA_W-1:0] hist  [N];
  logic signed [COEF_W-1:0] mcoef [N];
  logic [ACC_W-1:0]         sb_q  [$];
  int                       acc_q [$];
  logic                     prev_ov = 1'b0;
  logic [ACC_W-1:0]         last_out;
  logic [ACC_W-1:0]         held_exp;
  logic [ACC_W-1:0]         e_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accept -> model + push; first out_valid -> latency; handshake -> pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        longint s;
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_data;
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(hist[k]) * longint'(mcoef[k]);
        sb_q.push_back(s[ACC_W-1:0]);
        acc_q.push_back(cyc + 1);
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
        else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(N));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
        else chk("out_data", 32'(out_data), 32'(sb_q.pop_front()));
        last_out = out_data;
      end
    end
    prev_ov = out_valid;
  end

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      hist[i]  = '0;
      mcoef[i] = '0;
    end
    sb_q.delete();
    acc_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_coef(input int addr, input logic [COEF_W-1:0] val, input bit ok);
    @(posedge clk);
    #1;
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = val;
    if (ok) mcoef[addr] = val;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic set_coef_ramp();
    for (int k = 0; k < N; k++) write_coef(k, COEF_W'(k + 1), 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    out_ready  = 1'b1;
    flush_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);

    // Impulse through a ramp of coefficients.
    set_coef_ramp();
    send(12'd1);
    for (int i = 0; i < 21; i++) send(12'd0);
    drain();
    chk("impulse_tail", 32'(last_out), 32'd0);

    // All-ones filter: walks the write pointer past the modulo-20 wrap.
    for (int k = 0; k < N; k++) write_coef(k, 12'd1, 1'b1);
    for (int i = 0; i < 25; i++) send(12'd1);
    drain();
    chk("wrap_steady", 32'(last_out), 32'd20);

    // Extreme signed products on tap 0 only.
    write_coef(0, COEF_W'(-2048), 1'b1);
    for (int k = 1; k < N; k++) write_coef(k, 12'd0, 1'b1);
    send(DATA_W'(-2048));
    drain();
    e_val = ACC_W'(4194304);
    chk("neg_x_neg", 32'(last_out), 32'(e_val));
    send(12'd2047);
    drain();
    e_val = ACC_W'(-4192256);
    chk("pos_x_neg", 32'(last_out), 32'(e_val));

    // Backpressure: result must hold and new samples must be ignored.
    out_ready = 1'b0;
    send(12'd100);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    chk("bp_reached_out", 32'(out_valid), 32'd1);
    held_exp = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 12'd5;
      @(negedge clk);
      chk("bp_hold",     32'(out_data),  32'(held_exp));
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);
    drain();

    // Coefficient write while busy is dropped and flagged.
    send(12'd3);
    write_coef(0, 12'd5, 1'b0);
    @(negedge clk);
    chk("cfg_err_mac", 32'(cfg_err), 32'd1);
    drain();
    send(12'd1);
    drain();
    e_val = ACC_W'(-2048);
    chk("coef_unchanged", 32'(last_out), 32'(e_val));
    chk("cfg_err_sticky", 32'(cfg_err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("cfg_err_cleared", 32'(cfg_err), 32'd0);

    // Out-of-range address in IDLE.
    write_coef(25, 12'd7, 1'b0);
    @(negedge clk);
    chk("cfg_err_oor", 32'(cfg_err), 32'd1);
    send(12'd9);
    drain();
    chk("oor_no_effect", 32'(last_out), 32'd0);
    chk("cfg_err_oor_sticky", 32'(cfg_err), 32'd1);

    // Build history, then reset in the middle of a MAC run at k=7.
    set_coef_ramp();
    send(12'd7);
    send(12'd2);
    drain();
    send(12'd4);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    flush_model();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready),  32'd1);
    chk("post_rst_cfg",   32'(cfg_err),   32'd0);
    set_coef_ramp();
    send(12'd1);
    for (int i = 0; i < 19; i++) send(12'd0);
    drain();
    chk("reimpulse_last", 32'(last_out), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
